// File: rtl/fp_pkg.sv
// Shared definitions for the fp32 sequential operators.
package fp_pkg;

  localparam int XLEN    = 32;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int MANT_W  = 24;
  localparam int PROD_W  = 48;
  localparam int EXPS_W  = 10;
  localparam int CNT_W   = 5;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [XLEN-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_NORM,
    S_PACK,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    CLS_NORMAL,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } cls_e;

  // Operand-pair class; denormals count as zero (flush-to-zero).
  function automatic cls_e classify(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    logic x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
    x_zero = (x[30:23] == '0);
    y_zero = (y[30:23] == '0);
    x_inf  = (x[30:23] == '1) && (x[22:0] == '0);
    y_inf  = (y[30:23] == '1) && (y[22:0] == '0);
    x_nan  = (x[30:23] == '1) && (x[22:0] != '0);
    y_nan  = (y[30:23] == '1) && (y[22:0] != '0);
    if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) begin
      return CLS_NAN;
    end else if (x_inf || y_inf) begin
      return CLS_INF;
    end else if (x_zero || y_zero) begin
      return CLS_ZERO;
    end else begin
      return CLS_NORMAL;
    end
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalize a raw 48-bit mantissa product, round to nearest-even and
// pack it as fp32, with special classes overriding the datapath result.
module fp_round_pack
  import fp_pkg::*;
(
  input  logic                     sign_i,
  input  logic signed [EXPS_W-1:0] exp_i,
  input  logic [PROD_W-1:0]        prod_i,
  input  cls_e                     cls_i,
  output logic [XLEN-1:0]          result_o,
  output logic                     overflow_o,
  output logic                     underflow_o,
  output logic                     exception_o
);

  logic [FRAC_W-1:0]        frac;
  logic [FRAC_W-1:0]        frac_r;
  logic                     guard;
  logic                     sticky;
  logic                     rnd_up;
  logic                     carry;
  logic signed [EXPS_W-1:0] exp_n;
  logic signed [EXPS_W-1:0] exp_r;

  // Normalize, round, then range-check and pack.
  always_comb begin
    if (prod_i[PROD_W-1]) begin
      frac   = prod_i[46:24];
      guard  = prod_i[23];
      sticky = |prod_i[22:0];
      exp_n  = exp_i + 10'sd1;
    end else begin
      frac   = prod_i[45:23];
      guard  = prod_i[22];
      sticky = |prod_i[21:0];
      exp_n  = exp_i;
    end

    rnd_up = guard & (sticky | frac[0]);
    // Rounding carries out of the mantissa only when the fraction is all ones;
    // the fraction then wraps to zero and the exponent moves up by one.
    carry  = rnd_up & (&frac);
    frac_r = frac + {{(FRAC_W-1){1'b0}}, rnd_up};
    exp_r  = exp_n + $signed({{(EXPS_W-1){1'b0}}, carry});

    result_o    = '0;
    overflow_o  = 1'b0;
    underflow_o = 1'b0;
    exception_o = 1'b0;
    case (cls_i)
      CLS_NAN: begin
        result_o    = QNAN;
        exception_o = 1'b1;
      end
      CLS_INF:  result_o = {sign_i, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      CLS_ZERO: result_o = {sign_i, {(XLEN-1){1'b0}}};
      default: begin
        if (exp_r >= EXPS_W'(EXP_MAX)) begin
          result_o   = {sign_i, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          overflow_o = 1'b1;
        end else if (exp_r[EXPS_W-1] || (exp_r == '0)) begin
          result_o    = {sign_i, {(XLEN-1){1'b0}}};
          underflow_o = 1'b1;
        end else begin
          result_o = {sign_i, exp_r[EXP_W-1:0], frac_r};
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_mult_seq.sv
// Sequential fp32 multiplier: shift-and-add mantissa product, one bit per
// cycle, behind a valid/ready handshake with one operation in flight.
module fp_mult_seq
  import fp_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            underflow,
  output logic            exception,
  output logic            out_valid,
  input  logic            out_ready
);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [PROD_W-1:0]        acc_q, acc_d;
  logic [PROD_W-1:0]        mcand_q, mcand_d;
  logic [MANT_W-1:0]        mplier_q, mplier_d;
  logic                     sign_q, sign_d;
  logic signed [EXPS_W-1:0] exp_q, exp_d;
  cls_e                     cls_q, cls_d;
  logic [XLEN-1:0]          result_q, result_d;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;
  logic                     exc_q, exc_d;

  logic [XLEN-1:0]          pk_result;
  logic                     pk_ovf;
  logic                     pk_unf;
  logic                     pk_exc;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign exception = exc_q;

  fp_round_pack u_round_pack (
    .sign_i      (sign_q),
    .exp_i       (exp_q),
    .prod_i      (acc_q),
    .cls_i       (cls_q),
    .result_o    (pk_result),
    .overflow_o  (pk_ovf),
    .underflow_o (pk_unf),
    .exception_o (pk_exc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed 24-cycle multiply, then normalize/pack, then hold.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = S_MULT;
      S_MULT: if (cnt_q == CNT_W'(MANT_W - 1)) state_d = S_NORM;
      S_NORM: state_d = S_PACK;
      S_PACK: state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: operand capture, shift-and-add, result latch.
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    cls_d    = cls_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    exc_d    = exc_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d   = a[31] ^ b[31];
          exp_d    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]})
                     - EXPS_W'(BIAS);
          mcand_d  = {{(PROD_W-MANT_W){1'b0}}, |a[30:23], a[22:0]};
          mplier_d = {|b[30:23], b[22:0]};
          cls_d    = classify(a, b);
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      S_MULT: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
      end
      S_PACK: begin
        result_d = pk_result;
        ovf_d    = pk_ovf;
        unf_d    = pk_unf;
        exc_d    = pk_exc;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears the in-flight operation and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      cls_q    <= CLS_NORMAL;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      cls_q    <= cls_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      exc_q    <= exc_d;
    end
  end

endmodule

// File: tb/tb_fp_mult_seq.sv
// Scoreboard bench for fp_mult_seq.
module tb_fp_mult_seq;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [2:0]  f;   // {overflow, underflow, exception}
  } vec_t;

  localparam int NVEC = 18;

  vec_t vecs [NVEC] = '{
    '{32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000},
    '{32'h40400000, 32'h3EAAAAAB, 32'h3F800000, 3'b000},
    '{32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000},
    '{32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100},
    '{32'h00800000, 32'h3F000000, 32'h00000000, 3'b010},
    '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001},
    '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b001},
    '{32'h7F800000, 32'hC0000000, 32'hFF800000, 3'b000},
    '{32'h00000000, 32'hBF800000, 32'h80000000, 3'b000},
    '{32'h00000001, 32'h3F800000, 32'h00000000, 3'b000},
    '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000},
    '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 3'b000},
    '{32'h40A00000, 32'h40E00000, 32'h420C0000, 3'b000},
    '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 3'b000},
    '{32'h00800000, 32'h3F800000, 32'h00800000, 3'b000},
    '{32'hFF000000, 32'h40000000, 32'hFF800000, 3'b100},
    '{32'h00000005, 32'hFF800000, 32'h7FC00000, 3'b001},
    '{32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 3'b000}
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        exception;
  logic        out_valid;
  logic        out_ready;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [34:0] exp_q [$];
  int          acc_cyc_q [$];
  logic        ov_prev = 1'b0;
  int          t_acc;
  logic [34:0] e_exp;

  fp_mult_seq dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .exception (exception),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
    end
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic drive_op(input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] er, input logic [2:0] ef);
    int n;
    n = 0;
    a = av;
    b = bv;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check_eq("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      acc_cyc_q.push_back(cyc);
      exp_q.push_back({er, ef});
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: latency on each rising out_valid, data on each consume.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !ov_prev) begin
        if (acc_cyc_q.size() == 0) begin
          check_eq("spurious_valid", 64'd1, 64'd0);
        end else begin
          t_acc = acc_cyc_q.pop_front();
          check_eq("latency", 64'(cyc - t_acc), 64'd26);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", 64'd1, 64'd0);
        end else begin
          e_exp = exp_q.pop_front();
          check_eq("result", {29'd0, result, overflow, underflow, exception}, {29'd0, e_exp});
        end
      end
    end
    ov_prev = out_valid;
  end

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_flags", {overflow, underflow, exception}, 0);
    rst = 1'b0;
    out_ready = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive_op(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].f);
    end
    drain(200);

    // Reset and in_valid together: nothing may be accepted.
    a = 32'h40400000;
    b = 32'h40400000;
    in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    check_eq("rst_wins_in_ready", in_ready, 1);
    @(posedge clk); #1;
    check_eq("rst_wins_idle", {in_ready, out_valid}, 2'b10);

    // Backpressure: result held, new operands ignored while in DONE.
    out_ready = 1'b0;
    drive_op(32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("bp_valid", out_valid, 1);
    a = 32'h40A00000;
    b = 32'h40E00000;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check_eq("bp_hold", {result, overflow, underflow, exception, out_valid, in_ready},
               {32'h40400000, 3'b000, 1'b1, 1'b0});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(10);
    repeat (40) @(posedge clk);
    #1;
    check_eq("bp_ignored_in", {in_ready, out_valid}, 2'b10);
    check_eq("bp_no_pending", 64'(acc_cyc_q.size()), 64'd0);

    // Reset at MULT count 12 discards the operation.
    drive_op(32'h40A00000, 32'h40E00000, 32'h420C0000, 3'b000);
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    acc_cyc_q.delete();
    check_eq("midrst_in_ready", in_ready, 1);
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_result", result, 0);
    check_eq("midrst_flags", {overflow, underflow, exception}, 0);
    drive_op(32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000);
    drain(100);
    repeat (5) @(posedge clk);
    #1;
    check_eq("final_idle", {in_ready, out_valid}, 2'b10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
